// File: rtl/uart_word_rx_if.sv
// uart_word_rx_if: serial input, slave busy flag and word-presentation outputs of uart_word_rx; UART_PARITY_CHECK_EN adds parity_err.
interface uart_word_rx_if;
    logic        rx;
    logic        dirty;
    logic [15:0] word_out;
    logic        word_valid;
    logic        fifo_full;
    logic        overrun;
    logic        frame_err;
`ifdef UART_PARITY_CHECK_EN
    logic        parity_err;
`endif
    modport master (
        input  rx, dirty,
        output word_out, word_valid, fifo_full, overrun, frame_err
`ifdef UART_PARITY_CHECK_EN
        , output parity_err
`endif
    );
    modport slave (
        output rx, dirty,
        input  word_out, word_valid, fifo_full, overrun, frame_err
`ifdef UART_PARITY_CHECK_EN
        , input parity_err
`endif
    );
endinterface

// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 receiver pairing bytes low-first into 16-bit words, FIFO-buffered and offered when the slave is not dirty.
// Defining UART_PARITY_CHECK_EN switches the frame to 8E1 and adds the sticky parity_err flag.
module uart_word_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input logic            clk,
    input logic            rst,
    uart_word_rx_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_CHECK_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;
    typedef enum logic {TX_IDLE, TX_HOLD} tx_state_t;

`ifdef UART_PARITY_CHECK_EN
    localparam rx_state_t AFTER_DATA = RX_PARITY;
`else
    localparam rx_state_t AFTER_DATA = RX_STOP;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx, r_rx_prev;
    rx_state_t              r_rx_st, w_rx_n;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit;
    logic [7:0]             r_shift, r_low;
    logic                   r_pend, r_brk, r_frame_err, r_push;
    logic [15:0]            r_push_word;
    logic                   w_tick, w_good, w_bad, w_brk_set, w_par_bad;

    logic [15:0]            r_mem [FIFO_DEPTH];
    logic [AW:0]            r_wptr, r_rptr, w_count, w_count_n;
    logic                   w_empty, w_full, w_pop, w_wr;
    logic                   r_full, r_overrun, r_valid, r_hcnt;
    logic [15:0]            r_word;
    tx_state_t              r_tx_st, w_tx_n;

    assign w_rx = r_sync[SYNC_STAGES-1];

`ifdef UART_PARITY_CHECK_EN
    logic r_par_bad, r_parity_err;
    assign w_par_bad      = r_par_bad;
    assign bus.parity_err = r_parity_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else if (r_rx_st == RX_PARITY && w_tick) begin
            r_par_bad    <= ^{r_shift, w_rx};
            r_parity_err <= r_parity_err || ^{r_shift, w_rx};
        end
    end
`else
    assign w_par_bad = 1'b0;
`endif

    always_comb begin
        w_rx_n    = r_rx_st;
        w_good    = 1'b0;
        w_bad     = 1'b0;
        w_brk_set = 1'b0;
        w_tick    = r_cnt == ((r_rx_st == RX_START) ? HALF_M1 : FULL_M1);
        case (r_rx_st)
            RX_IDLE:   w_rx_n = (r_rx_prev && !w_rx) ? RX_START : RX_IDLE;
            RX_START:  if (w_tick) w_rx_n = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_tick && r_bit == 3'd7) w_rx_n = AFTER_DATA;
`ifdef UART_PARITY_CHECK_EN
            RX_PARITY: if (w_tick) w_rx_n = RX_STOP;
`endif
            RX_STOP: begin
                // a low stop bit parks here until the line returns high
                if (r_brk) begin
                    w_rx_n = w_rx ? RX_IDLE : RX_STOP;
                end else if (w_tick) begin
                    w_good    = w_rx && !w_par_bad;
                    w_bad     = !(w_rx && !w_par_bad);
                    w_brk_set = !w_rx;
                    w_rx_n    = w_rx ? RX_IDLE : RX_STOP;
                end
            end
            default:   w_rx_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync      <= '1;
            r_rx_prev   <= 1'b1;
            r_rx_st     <= RX_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_low       <= '0;
            r_pend      <= 1'b0;
            r_brk       <= 1'b0;
            r_frame_err <= 1'b0;
            r_push      <= 1'b0;
            r_push_word <= '0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.rx};
            r_rx_prev   <= w_rx;
            r_rx_st     <= w_rx_n;
            r_cnt       <= (r_rx_st == RX_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
            r_bit       <= (r_rx_st == RX_START) ? 3'd0 : (r_rx_st == RX_DATA && w_tick) ? r_bit + 3'd1 : r_bit;
            r_brk       <= (r_brk && r_rx_st == RX_STOP && !w_rx) || w_brk_set;
            r_frame_err <= r_frame_err || w_brk_set;
            r_pend      <= w_good ? !r_pend : w_bad ? 1'b0 : r_pend;
            r_push      <= w_good && r_pend;
            if (r_rx_st == RX_DATA && w_tick) r_shift <= {w_rx, r_shift[7:1]};
            if (w_good && !r_pend) r_low <= r_shift;
            if (w_good && r_pend) r_push_word <= {r_shift, r_low};
        end
    end

    assign w_count   = r_wptr - r_rptr;
    assign w_empty   = w_count == '0;
    assign w_full    = w_count == (AW+1)'(FIFO_DEPTH);
    // a full FIFO still accepts the push when the head leaves in the same cycle
    assign w_wr      = r_push && (!w_full || w_pop);
    assign w_count_n = w_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};

    always_comb begin
        w_pop  = 1'b0;
        w_tx_n = r_tx_st;
        w_pop  = r_tx_st == TX_IDLE && !w_empty && !bus.dirty;
        w_tx_n = w_pop ? TX_HOLD : (r_tx_st == TX_HOLD && r_hcnt) ? TX_IDLE : r_tx_st;
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_push_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
            r_tx_st   <= TX_IDLE;
            r_hcnt    <= 1'b0;
            r_valid   <= 1'b0;
            r_word    <= '0;
        end else begin
            r_tx_st   <= w_tx_n;
            r_hcnt    <= r_tx_st == TX_HOLD && !r_hcnt;
            r_valid   <= w_pop;
            r_full    <= w_count_n == (AW+1)'(FIFO_DEPTH);
            r_overrun <= r_overrun || (r_push && w_full && !w_pop);
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_pop) r_word <= r_mem[r_rptr[AW-1:0]];
        end
    end

    assign bus.word_out   = r_word;
    assign bus.word_valid = r_valid;
    assign bus.fifo_full  = r_full;
    assign bus.overrun    = r_overrun;
    assign bus.frame_err  = r_frame_err;
endmodule

// File: doc/uart_word_rx.md
Name: uart_word_rx

Overview:
- Upstream feeder for the FPGA slave stage. Receives 8N1 serial bytes from the external transmitter link.
- Pairs consecutive bytes into 16-bit words, low byte first, and buffers them in a small FIFO.
- Presents each word on word_out with a one-cycle word_valid pulse, which drives the slave's in_enable. Presentation is gated by the slave's dirty flag, so no word is offered while the slave still holds one.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range is at least 4.
- FIFO_DEPTH, 4, word FIFO entries; must be a power of two, at least 2.
- SYNC_STAGES, 2, rx synchronizer flops; at least 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- dirty  input  1  slave busy flag; 1 = slave holds a word.
- word_out  output  16  word offered to slave (in_data).
- word_valid  output  1  one-cycle strobe (in_enable).
- fifo_full  output  1  FIFO holds FIFO_DEPTH words.
- overrun  output  1  sticky: a word was dropped because the FIFO was full.
- frame_err  output  1  sticky: a stop bit was sampled low.

Behaviour:
- Reset: rst low asynchronously clears all state.
  - Outputs: word_out=0, word_valid=0, fifo_full=0, overrun=0, frame_err=0.
  - Internal: FIFO emptied, byte pairing cleared, both FSMs to IDLE, synchronizer flops set to 1.
  - Reset mid-frame or mid-handshake aborts the activity; no partial word survives.
- rx passes through SYNC_STAGES flops. All RX FSM decisions use the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a sync_rx 1→0 transition enters START and clears the bit-timer.
  - START: at CLKS_PER_BIT/2 (integer divide), sample sync_rx. If 0, enter DATA with bit index 0. If 1, the event was a glitch: return to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits. After bit 7, enter STOP.
  - STOP: sample after CLKS_PER_BIT. If 1, the byte is good. If 0, set frame_err, discard the byte, clear the pending low byte, and return to IDLE only once sync_rx=1.
- Byte pairing:
  - First good byte is stored as the low byte; pending flag set.
  - Second good byte forms {byte2, byte1} and issues one push request in the cycle STOP completes; pending flag cleared.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address, for full/empty detection.
  - Push when full and no pop this cycle: word dropped, overrun set.
  - Push and pop in the same cycle when full: both succeed; count unchanged, overrun not set.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_full is registered from the post-update count.
- TX FSM states: IDLE, HOLD.
  - IDLE: if the FIFO is non-empty and dirty=0, pop the head in this cycle. On the next edge word_out gets the head and word_valid=1 for exactly one cycle; enter HOLD.
  - HOLD: word_valid=0. Stay for 2 cycles regardless of dirty, because the slave sets dirty one edge after capture. Then return to IDLE.
  - IDLE re-checks dirty. If dirty=1, wait; while waiting, word_out holds the last presented value.
  - Minimum spacing between word_valid pulses is 3 cycles.
- Latency: stop-bit sample of the high byte → word_valid is 2 cycles when the FIFO was empty, dirty=0, and TX is idle (push 1 cycle, pop/present 1 cycle).
- Sticky flags clear only on reset.

Optional Feature:
- Macro UART_PARITY_CHECK_EN.
- Defined:
  - Frame becomes 8E1. New state PARITY sits between DATA and STOP and samples the parity bit.
  - A parity mismatch (XOR of 8 data bits and the parity bit ≠ 0) discards the byte and clears the pending low byte, exactly like a frame error.
  - Adds output port parity_err (1-bit sticky, reset 0).
- Undefined: 8N1 only; no PARITY state, no parity_err port.

Test Plan:
- CLKS_PER_BIT=16, dirty=0; send bytes 0x34, 0x12 → one word_valid pulse with word_out=0x1234, 2 cycles after the second stop sample; fifo_full=0.
- dirty held 1; send 5 words 0x0001..0x0005 (FIFO_DEPTH=4) → fifo_full=1 after the 4th word, 5th dropped, overrun=1. Then release dirty, pulsing it 1 for 2 cycles after each word_valid → words 0x0001..0x0004 delivered in order, each pulse ≥3 cycles apart.
- Low byte 0xAA with stop bit forced 0, then bytes 0xCD, 0xAB → frame_err=1, single word 0xABCD (0xAA not paired).
- rx glitch low for 3 cycles (shorter than CLKS_PER_BIT/2), then a valid pair 0x55, 0x66 → no frame_err, word 0x6655 only.
- Assert rst low mid-DATA of the high byte, then release → all outputs 0, FIFO empty. A following pair 0x11, 0x22 yields 0x2211.
- With UART_PARITY_CHECK_EN: byte 0x07 with wrong parity, then pair 0x01, 0x02 with correct parity → parity_err=1, only 0x0201 delivered.
